// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller: register indices,
// claim-word layout, hard_int bit assignment and the claim priority helper.
package intc_pkg;

  localparam int N_SRC = 5;

  // Word index of each register on the data-memory bus port
  typedef enum logic [2:0] {
    INTC_PENDING = 3'd0,
    INTC_MASK    = 3'd1,
    INTC_MODE    = 3'd2,
    INTC_CLAIM   = 3'd3,
    INTC_COUNT   = 3'd4,
    INTC_COMPARE = 3'd5,
    INTC_STATUS  = 3'd6,
    INTC_RSVD    = 3'd7
  } intc_reg_e;

  // Bit set in a claim read when a source was found
  localparam int INTC_CLAIM_VALID = 31;

  // hard_int layout: [4:0] external sources 1:1, [5] timer (cop0 CAUSE[15:10])
  localparam int HINT_TIMER = 5;

  // Out of reset every source is rising-edge qualified
  localparam logic [N_SRC-1:0] MODE_RESET = '1;

  // Lowest-index set bit of v: returns {found, id[4:0]}
  function automatic logic [5:0] lowest_set(input logic [N_SRC-1:0] v);
    logic [5:0] r;
    r = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (v[i]) r = {1'b1, 5'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/intc_sync.sv
// One request line: two-flop synchronizer followed by a rising-edge
// detector; set_o is the qualified "mark pending" condition.
module intc_sync (
  input  logic clk,
  input  logic rst,
  input  logic irq_i,
  input  logic mode_i,
  output logic set_o
);

  logic s1_q, s2_q, prev_q;

  // Synchronize the asynchronous request and keep the previous synced value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= irq_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  // Edge mode fires only on a 0->1 transition, level mode while high
  assign set_o = mode_i ? (s2_q & ~prev_q) : s2_q;

endmodule

// File: rtl/intc.sv
// Interrupt controller feeding cop0 hard_int[5:0]: five qualified external
// sources latched as pending and masked onto [4:0], count/compare timer on [5],
// serviced through a word-addressed register port.
module intc
  import intc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq,
  input  logic [2:0]       addr,
  input  logic             wr,
  input  logic             rd,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic [5:0]       hard_int
);

  logic [N_SRC-1:0] set_w;
  logic [N_SRC-1:0] pend_q, pend_d, mask_q, mode_q, clr_w;
  logic [31:0]      count_q, count_d, cmp_q, rd_val;
  logic             tpend_q, tpend_d;
  logic [5:0]       claim_w;
  logic [5:0]       hint_d;

  for (genvar g = 0; g < N_SRC; g++) begin : g_sync
    intc_sync u_sync (
      .clk    (clk),
      .rst    (rst),
      .irq_i  (irq[g]),
      .mode_i (mode_q[g]),
      .set_o  (set_w[g])
    );
  end

  assign claim_w = lowest_set(pend_q & mask_q);

  // Read mux over the current (pre-write) register values
  always_comb begin
    rd_val = '0;
    case (intc_reg_e'(addr))
      INTC_PENDING: rd_val = {27'b0, pend_q};
      INTC_MASK:    rd_val = {27'b0, mask_q};
      INTC_MODE:    rd_val = {27'b0, mode_q};
      INTC_CLAIM: begin
        if (claim_w[5]) begin
          rd_val[INTC_CLAIM_VALID] = 1'b1;
          rd_val[4:0]              = claim_w[4:0];
        end
      end
      INTC_COUNT:   rd_val = count_q;
      INTC_COMPARE: rd_val = cmp_q;
      INTC_STATUS:  rd_val = {26'b0, hard_int};
      default:      rd_val = '0;
    endcase
  end

  // Next-state for pending bits, timer and output vector
  always_comb begin
    clr_w = '0;
    if (wr && addr == INTC_PENDING) clr_w = wdata[N_SRC-1:0];
    // Claiming an edge source consumes it; level sources stay until quiesced
    if (rd && addr == INTC_CLAIM && claim_w[5] && mode_q[claim_w[2:0]])
      clr_w[claim_w[2:0]] = 1'b1;
    // New requests win over any clear in the same cycle
    pend_d  = (pend_q & ~clr_w) | set_w;
    count_d = (wr && addr == INTC_COUNT) ? wdata : count_q + 32'd1;
    // A COMPARE write beats a coincident match
    tpend_d = (wr && addr == INTC_COMPARE) ? 1'b0
            : (tpend_q | ((count_q == cmp_q) && (cmp_q != 32'd0)));
    hint_d                 = '0;
    hint_d[N_SRC-1:0]      = pend_q & mask_q;
    hint_d[HINT_TIMER]     = tpend_q;
  end

  // Architectural state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q   <= '0;
      mask_q   <= '0;
      mode_q   <= MODE_RESET;
      count_q  <= '0;
      cmp_q    <= '0;
      tpend_q  <= 1'b0;
      rdata    <= '0;
      hard_int <= '0;
    end else begin
      pend_q   <= pend_d;
      count_q  <= count_d;
      tpend_q  <= tpend_d;
      hard_int <= hint_d;
      if (wr && addr == INTC_MASK)    mask_q <= wdata[N_SRC-1:0];
      if (wr && addr == INTC_MODE)    mode_q <= wdata[N_SRC-1:0];
      if (wr && addr == INTC_COMPARE) cmp_q  <= wdata;
      if (rd)                         rdata  <= rd_val;
    end
  end

endmodule

// File: tb/tb_intc.sv
// Self-checking bench for intc: directed walk through the main behaviours,
// then a randomized register/irq phase, all against a behavioural model.
module tb_intc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  irq = '0;
  logic [2:0]  addr = '0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [5:0]  hard_int;

  intc dut (
    .clk      (clk),
    .rst      (rst),
    .irq      (irq),
    .addr     (addr),
    .wr       (wr),
    .rd       (rd),
    .wdata    (wdata),
    .rdata    (rdata),
    .hard_int (hard_int)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model state
  logic [4:0]  m_pend, m_mask, m_mode;
  logic [31:0] m_count, m_cmp, m_rdata;
  logic        m_tpend;
  logic [5:0]  m_hint;
  // seen[k]: irq as sampled k+1 clock edges ago
  logic [4:0]  seen [0:2];

  task automatic model_reset();
    m_pend = '0; m_mask = '0; m_mode = 5'h1F;
    m_count = '0; m_cmp = '0; m_rdata = '0;
    m_tpend = 1'b0; m_hint = '0;
    for (int k = 0; k < 3; k++) seen[k] = '0;
  endtask

  // Advance the model by one clock edge using the inputs now applied
  task automatic model_step();
    logic [4:0]  s, p, setv, clr, act;
    logic [31:0] rv;
    int          id;
    s    = seen[1];
    p    = seen[2];
    setv = (m_mode & s & ~p) | (~m_mode & s);
    act  = m_pend & m_mask;
    id   = -1;
    for (int i = 4; i >= 0; i--) if (act[i]) id = i;
    rv = m_rdata;
    if (rd) begin
      case (addr)
        3'd0: rv = {27'b0, m_pend};
        3'd1: rv = {27'b0, m_mask};
        3'd2: rv = {27'b0, m_mode};
        3'd3: rv = (id >= 0) ? (32'h8000_0000 | 32'(id)) : 32'h0;
        3'd4: rv = m_count;
        3'd5: rv = m_cmp;
        3'd6: rv = {26'b0, m_hint};
        default: rv = 32'h0;
      endcase
    end
    clr = '0;
    if (rd && addr == 3'd3 && id >= 0 && m_mode[id]) clr[id] = 1'b1;
    if (wr && addr == 3'd0) clr = clr | wdata[4:0];
    m_hint  = {m_tpend, act};
    m_tpend = (wr && addr == 3'd5) ? 1'b0
            : (m_tpend | (m_count == m_cmp && m_cmp != 0));
    m_count = (wr && addr == 3'd4) ? wdata : m_count + 1;
    if (wr && addr == 3'd5) m_cmp  = wdata;
    if (wr && addr == 3'd1) m_mask = wdata[4:0];
    if (wr && addr == 3'd2) m_mode = wdata[4:0];
    m_pend  = (m_pend & ~clr) | setv;
    m_rdata = rv;
    seen[2] = seen[1];
    seen[1] = seen[0];
    seen[0] = irq;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock: update model, let the edge happen, compare outputs 1 time unit later
  task automatic tick();
    if (rst) model_reset(); else model_step();
    @(posedge clk);
    #1;
    chk("hard_int", 32'(hard_int), 32'(m_hint));
    chk("rdata", rdata, m_rdata);
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr = 1'b1;
    tick();
    wr = 1'b0;
  endtask

  task automatic rd_reg(input logic [2:0] a, output logic [31:0] d);
    addr = a; rd = 1'b1;
    tick();
    rd = 1'b0;
    d = rdata;
  endtask

  logic [31:0] v;
  int          op;

  initial begin
    model_reset();
    // Reset state
    tick(); tick();
    chk("reset_hard_int", 32'(hard_int), 32'h0);
    chk("reset_rdata", rdata, 32'h0);
    rst = 1'b0;

    // Edge source 2, fully unmasked
    wr_reg(3'd1, 32'h1F);
    irq = 5'b00100;
    tick(); tick();
    irq = '0;
    tick();
    chk("edge_hint_early", 32'(hard_int), 32'h0);
    rd_reg(3'd0, v);
    chk("edge_pend", v, 32'h04);
    chk("edge_hint", 32'(hard_int), 32'h04);
    rd_reg(3'd3, v);
    chk("claim2", v, 32'h8000_0002);
    tick();
    chk("claim2_hint_clear", 32'(hard_int), 32'h0);

    // Level source 0: W1C ineffective while high
    wr_reg(3'd2, 32'h00);
    irq = 5'b00001;
    tick(); tick(); tick();
    wr_reg(3'd0, 32'h01);
    rd_reg(3'd0, v);
    chk("level_w1c_held", v & 32'h1, 32'h1);
    irq = '0;
    tick(); tick(); tick();
    wr_reg(3'd0, 32'h01);
    rd_reg(3'd0, v);
    chk("level_w1c_clear", v, 32'h0);
    wr_reg(3'd2, 32'h1F);

    // Two simultaneous edges claimed in priority order
    irq = 5'b01010;
    tick(); tick(); tick();
    irq = '0;
    rd_reg(3'd3, v);
    chk("claim_first", v, 32'h8000_0001);
    rd_reg(3'd3, v);
    chk("claim_second", v, 32'h8000_0003);
    rd_reg(3'd3, v);
    chk("claim_none", v, 32'h0);

    // Timer compare
    wr_reg(3'd4, 32'd1000);
    wr_reg(3'd5, 32'd20);
    wr_reg(3'd4, 32'd10);
    repeat (11) tick();
    chk("timer_not_yet", 32'(hard_int), 32'h0);
    tick();
    chk("timer_fire", 32'(hard_int), 32'h20);
    rd_reg(3'd6, v);
    chk("status_read", v, 32'h20);
    wr_reg(3'd5, 32'd0);
    tick();
    chk("timer_cleared", 32'(hard_int), 32'h0);
    wr_reg(3'd4, 32'hFFFF_FFFE);
    tick(); tick();
    rd_reg(3'd4, v);
    chk("count_wrap0", v, 32'h0);
    rd_reg(3'd4, v);
    chk("count_wrap1", v, 32'h1);

    // Masked source 4
    wr_reg(3'd1, 32'h00);
    irq = 5'b10000;
    tick(); tick();
    irq = '0;
    tick(); tick();
    rd_reg(3'd0, v);
    chk("masked_pend", v, 32'h10);
    chk("masked_hint", 32'(hard_int), 32'h0);
    wr_reg(3'd1, 32'h10);
    tick();
    chk("unmask_hint", 32'(hard_int), 32'h10);

    // Asynchronous reset in the middle of a pulse
    irq = 5'b00001;
    tick();
    rst = 1'b1;
    model_reset();
    #1;
    chk("async_rst_hint", 32'(hard_int), 32'h0);
    chk("async_rst_rdata", rdata, 32'h0);
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    rd_reg(3'd0, v);
    chk("post_rst_edge", v, 32'h01);
    rd_reg(3'd1, v);
    chk("post_rst_mask", v, 32'h0);
    irq = '0;

    // Randomized traffic
    wr_reg(3'd1, 32'h1F);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) irq = irq ^ 5'($urandom_range(0, 31));
      op    = int'($urandom_range(0, 6));
      rd    = (op == 0 || op == 1 || op == 2);
      wr    = (op == 2 || op == 3);
      addr  = 3'($urandom_range(0, 7));
      wdata = $urandom;
      if (wr && (addr == 3'd1 || addr == 3'd0)) wdata = {27'b0, 5'($urandom_range(0, 31))};
      if (wr && addr == 3'd5 && $urandom_range(0, 1) == 1)
        wdata = m_count + 32'($urandom_range(2, 30));
      tick();
    end
    rd = 1'b0; wr = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
